// File: rtl/hamming_secded_codec_if.sv
// hamming_secded_codec_if: valid/ready bus for the SECDED codec.
//   in_valid/in_ready/in_mode/in_data      input word handshake (mode 0 = encode, 1 = decode)
//   out_valid/out_ready/out_mode/out_data  output word handshake
//   out_err                                00 clean, 01 corrected, 10 uncorrectable
//   master = producer/consumer side, slave = codec side.
interface hamming_secded_codec_if #(
    parameter int CW = 8
);
    logic          in_valid;
    logic          in_ready;
    logic          in_mode;
    logic [CW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_mode;
    logic [CW-1:0] out_data;
    logic [1:0]    out_err;

    modport master (
        output in_valid, in_mode, in_data, out_ready,
        input  in_ready, out_valid, out_mode, out_data, out_err
    );

    modport slave (
        input  in_valid, in_mode, in_data, out_ready,
        output in_ready, out_valid, out_mode, out_data, out_err
    );
endinterface

// File: rtl/hamming_secded_codec.sv
// hamming_secded_codec: 2-stage pipelined Hamming SECDED encoder/decoder with saturating error counters.
//   clk, rst_n  clock (rising edge), asynchronous active-low reset
//   clr_cnt     synchronous clear of both counters (wins over an increment)
//   bus         valid/ready word interface (slave side), codeword width CW
//   corr_cnt    decoded words reported as single-error corrected
//   uncorr_cnt  decoded words reported as uncorrectable
module hamming_secded_codec #(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr_cnt,
    hamming_secded_codec_if.slave bus,
    output logic [CNT_W-1:0]     corr_cnt,
    output logic [CNT_W-1:0]     uncorr_cnt
);
    function automatic int calc_p(input int dw);
        int p;
        p = 1;
        while ((1 << p) < dw + p + 1) p++;
        return p;
    endfunction

    localparam int P  = calc_p(DATA_W);
    localparam int CW = DATA_W + P + 1;

    logic          v1, v2, m1, q1, q_in, adv1, adv2, om, fire;
    logic [CW-1:0] w_in, w1, fixd, dat, code, od;
    logic [P-1:0]  s_in, s1;
    logic [1:0]    err, oe;

    assign adv2          = !v2 || bus.out_ready;
    assign adv1          = !v1 || adv2;
    assign bus.in_ready  = adv1;
    assign bus.out_valid = v2;
    assign bus.out_mode  = om;
    assign bus.out_data  = od;
    assign bus.out_err   = oe;
    assign fire          = v2 && bus.out_ready && om;

    // For encode the data is scattered into a codeword with zero parity bits; the
    // syndrome of that word is then exactly the parity-bit vector, so one XOR tree
    // serves both modes.
    always_comb begin : stage1_logic
        int n;
        n    = 0;
        w_in = '0;
        s_in = '0;
        for (int i = 1; i < CW; i++)
            if ((i & (i - 1)) != 0) begin
                w_in[i] = bus.in_data[n];
                n++;
            end
        if (bus.in_mode) w_in = bus.in_data;
        for (int i = 1; i < CW; i++)
            if (w_in[i]) s_in ^= P'(i);
        q_in = ^w_in;
    end

    always_comb begin : stage2_logic
        int n;
        n    = 0;
        fixd = w1;
        if (q1 && s1 != '0 && int'(s1) < CW) fixd[s1] = !w1[s1];
        err = !m1 ? 2'b00 :
              q1  ? (int'(s1) < CW ? 2'b01 : 2'b10) :
                    (s1 == '0 ? 2'b00 : 2'b10);
        dat = '0;
        for (int i = 1; i < CW; i++)
            if ((i & (i - 1)) != 0) begin
                dat[n] = fixd[i];
                n++;
            end
        code = w1;
        for (int k = 0; k < P; k++) code[1 << k] = s1[k];
        code[0] = ^code[CW-1:1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1         <= 1'b0;
            m1         <= 1'b0;
            q1         <= 1'b0;
            w1         <= '0;
            s1         <= '0;
            v2         <= 1'b0;
            om         <= 1'b0;
            od         <= '0;
            oe         <= 2'b00;
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else begin
            if (adv1) begin
                v1 <= bus.in_valid;
                m1 <= bus.in_mode;
                w1 <= w_in;
                s1 <= s_in;
                q1 <= q_in;
            end
            if (adv2) begin
                v2 <= v1;
                om <= m1;
                od <= m1 ? dat : code;
                oe <= err;
            end
            if (clr_cnt) begin
                corr_cnt   <= '0;
                uncorr_cnt <= '0;
            end else begin
                if (fire && oe == 2'b01 && corr_cnt != '1) corr_cnt <= corr_cnt + 1'b1;
                if (fire && oe == 2'b10 && uncorr_cnt != '1) uncorr_cnt <= uncorr_cnt + 1'b1;
            end
        end
    end
endmodule
